// File: rtl/pong_timing_pkg.sv
// Pong video timing constants and helpers.
// Shared by mod_n_counter and hv_counter.
package pong_timing_pkg;

  localparam int H_TOTAL = 455;
  localparam int V_TOTAL = 262;
  localparam int CW      = 9;

  // hcnt bit positions used by hsync
  localparam int H16 = 4;
  localparam int H32 = 5;
  localparam int H64 = 6;

  localparam int FRAME_ADV = H_TOTAL * V_TOTAL;

  // Next count for a mod-N counter. Anything
  // at or past the last value returns to 0, so
  // an illegal count recovers on one advance.
  function automatic logic [CW-1:0] mod_inc(
    input logic [CW-1:0] c,
    input logic [CW-1:0] last
  );
    logic [CW-1:0] r;
    if (c >= last) r = '0;
    else           r = CW'(c + 1'b1);
    return r;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Mod-N counter with registered last-count flag.
// Ports: clk, _reset (sync, low), ce -> cnt, at_max, wrap.
module mod_n_counter
  import pong_timing_pkg::*;
#(
  parameter int N = H_TOTAL
) (
  input  logic          clk,
  input  logic          _reset,
  input  logic          ce,
  output logic [CW-1:0] cnt,
  output logic          at_max,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;
  logic          r_at_max;
  logic [CW-1:0] w_nxt;

  assign w_nxt = mod_inc(r_cnt, LAST);

  // at_max is decoded from the next count so
  // it lines up with cnt without a cycle lag.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_cnt    <= '0;
      r_at_max <= 1'b0;
    end else if (ce) begin
      r_cnt    <= w_nxt;
      r_at_max <= (w_nxt == LAST);
    end
  end

  assign cnt    = r_cnt;
  assign at_max = r_at_max;
  assign wrap   = ce & (r_cnt == LAST);

endmodule

// File: rtl/hv_counter.sv
// Pong horizontal/vertical counter chain.
// Ports: mclk, _reset -> pix_ce, hcnt, vcnt,
//   hreset/_hreset, vreset/_vreset.
// Macro HV_COUNTER_DIV2_CE_EN: pix_ce = mclk/2.
module hv_counter
  import pong_timing_pkg::*;
(
  input  logic          mclk,
  input  logic          _reset,
  output logic          pix_ce,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hreset,
  output logic          _hreset,
  output logic          vreset,
  output logic          _vreset
);

  logic w_ce;
  logic w_hwrap;
  logic w_hmax;
  logic w_vmax;

`ifdef HV_COUNTER_DIV2_CE_EN
  // Toggle starts at 0: first advance lands
  // on the second edge after reset release.
  logic r_ce;

  always_ff @(posedge mclk) begin
    if (!_reset) r_ce <= 1'b0;
    else         r_ce <= ~r_ce;
  end

  assign w_ce = r_ce;
`else
  assign w_ce = 1'b1;
`endif

  mod_n_counter #(
    .N (H_TOTAL)
  ) u_hcnt (
    .clk    (mclk),
    ._reset (_reset),
    .ce     (w_ce),
    .cnt    (hcnt),
    .at_max (w_hmax),
    .wrap   (w_hwrap)
  );

  // Line advances on the pixel that wraps hcnt.
  mod_n_counter #(
    .N (V_TOTAL)
  ) u_vcnt (
    .clk    (mclk),
    ._reset (_reset),
    .ce     (w_hwrap),
    .cnt    (vcnt),
    .at_max (w_vmax),
    .wrap   ()
  );

  assign pix_ce  = w_ce;
  assign hreset  = w_hmax;
  assign _hreset = ~w_hmax;
  assign vreset  = w_vmax;
  assign _vreset = ~w_vmax;

endmodule

// File: tb/tb_hv_counter.sv
// Random + directed bench for hv_counter.
// Reference: linear advance position in frame.
module tb_hv_counter;
  import pong_timing_pkg::*;

`ifdef HV_COUNTER_DIV2_CE_EN
  localparam bit DIV2 = 1'b1;
`else
  localparam bit DIV2 = 1'b0;
`endif

  logic          mclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_ce;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          hreset;
  logic          hreset_n;
  logic          vreset;
  logic          vreset_n;

  hv_counter dut (
    .mclk    (mclk),
    ._reset  (rst_n),
    .pix_ce  (pix_ce),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .hreset  (hreset),
    ._hreset (hreset_n),
    .vreset  (vreset),
    ._vreset (vreset_n)
  );

  always #5 mclk = ~mclk;

  int n_chk  = 0;
  int n_fail = 0;
  int pos    = 0;
  bit ce_m   = 1'b0;
  bit chk_en = 1'b1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int eh();
    return pos % H_TOTAL;
  endfunction

  function automatic int ev();
    return pos / H_TOTAL;
  endfunction

  task automatic tick(
    input  logic rn,
    output bit   adv
  );
    rst_n = rn;
    @(posedge mclk);
    adv = 1'b0;
    if (!rn) begin
      pos  = 0;
      ce_m = !DIV2;
    end else begin
      if (ce_m) begin
        pos = (pos + 1) % FRAME_ADV;
        adv = 1'b1;
      end
      if (DIV2) ce_m = !ce_m;
    end
    @(negedge mclk);
    if (chk_en) begin
      check("hcnt", 32'(hcnt), 32'(eh()));
      check("vcnt", 32'(vcnt), 32'(ev()));
      check("hreset", 32'(hreset),
            32'(eh() == H_TOTAL - 1));
      check("_hreset", 32'(hreset_n),
            32'(eh() != H_TOTAL - 1));
      check("vreset", 32'(vreset),
            32'(ev() == V_TOTAL - 1));
      check("_vreset", 32'(vreset_n),
            32'(ev() != V_TOTAL - 1));
      check("pix_ce", 32'(pix_ce), 32'(ce_m));
    end
  endtask

  task automatic run_adv(input int k);
    int got;
    bit a;
    got = 0;
    for (int t = 0; t < 4 * k + 8; t++) begin
      if (got >= k) break;
      tick(1'b1, a);
      if (a) got++;
    end
  endtask

  task automatic force_v(input logic [CW-1:0] fv);
    force dut.u_vcnt.r_cnt = fv;
    #1;
    release dut.u_vcnt.r_cnt;
    pos = int'(fv) * H_TOTAL + eh();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int first;
    int hr_cnt, low_cnt, low_at, first80;
    int chg, vr_cnt, exp_adv;
    logic [CW-1:0] prev_h, v_keep;

    // Reset held 3 edges
    for (int i = 0; i < 3; i++) tick(1'b0, a);

    // First advance edge
    first = 0;
    for (int e = 1; e <= 4; e++) begin
      tick(1'b1, a);
      if (first == 0 && hcnt == 1) first = e;
    end
    check("first_adv_edge", 32'(first),
          DIV2 ? 32'd2 : 32'd1);

    // Line wrap and hsync bits
    hr_cnt = 0; low_cnt = 0;
    low_at = -1; first80 = -1;
    for (int t = 0; t < 2000; t++) begin
      if (vcnt == 1) break;
      tick(1'b1, a);
      if (a && vcnt == 0) begin
        if (hreset) hr_cnt++;
        if (!hreset_n) begin
          low_cnt++;
          low_at = int'(hcnt);
        end
        if (first80 < 0 && hcnt[H16] && hcnt[H64])
          first80 = int'(hcnt);
      end
    end
    check("line_hcnt", 32'(hcnt), 32'd0);
    check("line_vcnt", 32'(vcnt), 32'd1);
    check("hreset_adv", 32'(hr_cnt), 32'd1);
    check("hreset_n_low", 32'(low_cnt), 32'd1);
    check("hreset_n_at", 32'(low_at), 32'd454);
    check("h16_h64_first", 32'(first80), 32'd80);

    // CE gating over 10 edges
    tick(1'b0, a);
    chg = 0;
    prev_h = hcnt;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, a);
      if (hcnt != prev_h) chg++;
      prev_h = hcnt;
    end
    check("ce_counts", 32'(chg),
          DIV2 ? 32'd5 : 32'd10);

    // Frame wrap from line 260
    force_v(9'd260);
    exp_adv = FRAME_ADV - pos;
    chg = 0; vr_cnt = 0;
    prev_h = hcnt;
    for (int t = 0; t < 4 * exp_adv + 8; t++) begin
      tick(1'b1, a);
      if (hcnt != prev_h) begin
        chg++;
        if (vreset) vr_cnt++;
      end
      prev_h = hcnt;
      if (hcnt == 0 && vcnt == 0) break;
    end
    check("frame_adv", 32'(chg), 32'(exp_adv));
    check("vreset_adv", 32'(vr_cnt), 32'd455);
    check("frame_h0", 32'(hcnt), 32'd0);
    check("frame_v0", 32'(vcnt), 32'd0);

    // Illegal hcnt recovers on next advance
    run_adv(7);
    v_keep = vcnt;
    chk_en = 1'b0;
    force dut.u_hcnt.r_cnt = 9'd500;
    #1;
    release dut.u_hcnt.r_cnt;
    for (int t = 0; t < 4; t++) begin
      tick(1'b1, a);
      if (a) break;
    end
    check("illegal_h", 32'(hcnt), 32'd0);
    check("illegal_v", 32'(vcnt), 32'(v_keep));
    check("illegal_hr", 32'(hreset), 32'd0);
    pos = int'(v_keep) * H_TOTAL;
    chk_en = 1'b1;

    // Mid-frame reset at h=200, v=100
    force_v(9'd100);
    for (int t = 0; t < 2000; t++) begin
      if (eh() == 200) break;
      tick(1'b1, a);
    end
    check("pre_rst_h", 32'(hcnt), 32'd200);
    check("pre_rst_v", 32'(vcnt), 32'd100);
    tick(1'b0, a);
    check("mid_rst_h", 32'(hcnt), 32'd0);
    check("mid_rst_v", 32'(vcnt), 32'd0);
    check("mid_rst_hr", 32'(hreset), 32'd0);
    check("mid_rst_vr", 32'(vreset), 32'd0);
    run_adv(500);

    // Random runs, resets and line jumps
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int nr;
        nr = int'($urandom_range(1, 3));
        for (int r = 0; r < nr; r++)
          tick(1'b0, a);
      end
      if ($urandom_range(0, 2) == 0
          && ev() != V_TOTAL - 1)
        force_v(CW'($urandom_range(0, 260)));
      run_adv(int'($urandom_range(1, 600)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
